// File: rtl/demux8_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : demux8_dispatch_if
// Brief    : Bundles the upstream offer and the eight downstream lane
//            handshakes of the 1-to-8 dispatcher.
// Revision : 1.0
// ============================================================================
interface demux8_dispatch_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [2:0]           aluOP;
    logic [7:0]           out_valid;
    logic [7:0]           out_ready;
    logic [8*WIDTH-1:0]   out_data;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, aluOP, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Dispatcher side
    modport slave (
        input  in_valid, in_data, aluOP, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/demux8_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : demux8_dispatch
// Brief    : Routes each accepted word to one of eight one-entry output lanes
//            selected by aluOP. Also counts accepted words.
// Revision : 1.0
// ============================================================================
module demux8_dispatch #(
    parameter int WIDTH = 32
) (
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 flush,
    demux8_dispatch_if.slave    bus,
    output logic [15:0]         disp_count,
    output logic                busy
);
    localparam int LANES = 8;

    logic [LANES-1:0]       r_valid;
    logic [LANES*WIDTH-1:0] r_data;
    logic [15:0]            r_count;

    logic                   w_in_ready;
    logic                   w_in_xfer;
    logic [LANES-1:0]       w_load;
    logic [LANES-1:0]       w_drain;

    // Only the addressed lane can stall the offer; a lane draining this
    // cycle is free to take the new word in the same cycle.
    assign w_in_ready = !flush && (!r_valid[bus.aluOP] || bus.out_ready[bus.aluOP]);
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_drain    = r_valid & bus.out_ready;

    always_comb begin
        w_load = '0;
        if (w_in_xfer) begin
            w_load[bus.aluOP] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else if (flush) begin
            // Lane contents are left stale; only occupancy and count clear.
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= (r_valid & ~w_drain) | w_load;
            if (w_in_xfer) begin
                r_data[WIDTH*bus.aluOP +: WIDTH] <= bus.in_data;
                r_count                          <= r_count + 16'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign disp_count    = r_count;
    assign busy          = |r_valid;
endmodule
`default_nettype wire

// File: tb/tb_demux8_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux8_dispatch
// Brief    : Directed scoreboard bench for demux8_dispatch.
// Revision : 1.0
// ============================================================================
module tb_demux8_dispatch;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] disp_count;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0]  lane;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    demux8_dispatch_if #(.WIDTH(32)) bus ();

    demux8_dispatch #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus),
        .disp_count (disp_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_data(input int k);
        return bus.out_data[32*k +: 32];
    endfunction

    // Drains are compared against the oldest outstanding word for that lane.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !flush) begin
                for (int k = 0; k < 8; k++) begin
                    if (bus.out_valid[k] && bus.out_ready[k]) begin
                        int idx;
                        idx = -1;
                        for (int j = 0; j < sb.size(); j++) begin
                            if (idx < 0 && sb[j].lane == 3'(k)) idx = j;
                        end
                        if (idx < 0) begin
                            chk("unexpected_drain_lane", 64'(k), 64'hFF);
                        end else begin
                            chk("drain_data", 64'(lane_data(k)), 64'(sb[idx].data));
                            sb.delete(idx);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; leaves inputs idle just after the next one.
    task automatic offer(input logic [2:0] lane, input logic [31:0] d,
                         input logic [7:0] ordy, input logic exp_rdy);
        bus.in_valid  = 1'b1;
        bus.aluOP     = lane;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        if (exp_rdy) sb.push_back('{lane: lane, data: d});
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.aluOP     = '0;
        bus.out_ready = 8'h00;
        #3;
        chk("reset_out_valid", 64'(bus.out_valid), 64'h00);
        chk("reset_count", 64'(disp_count), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_out_data", 64'(bus.out_data[63:0]), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready_no_valid", 64'(bus.in_ready), 64'h1);

        // First word into lane 5
        offer(3'd5, 32'hDEADBEEF, 8'h00, 1'b1);
        chk("first_out_valid", 64'(bus.out_valid), 64'h20);
        chk("first_lane5", 64'(lane_data(5)), 64'hDEADBEEF);
        chk("first_count", 64'(disp_count), 64'h1);
        chk("first_busy", 64'(busy), 64'h1);

        // Stalled lane 5 blocks only its own offers
        offer(3'd5, 32'h12345678, 8'h00, 1'b0);
        chk("stall_lane5", 64'(lane_data(5)), 64'hDEADBEEF);
        chk("stall_out_valid", 64'(bus.out_valid), 64'h20);
        chk("stall_count", 64'(disp_count), 64'h1);
        offer(3'd2, 32'hCAFE0002, 8'h00, 1'b1);
        chk("other_lane_out_valid", 64'(bus.out_valid), 64'h24);
        chk("other_lane_count", 64'(disp_count), 64'h2);

        // Simultaneous drain and refill of lane 3
        offer(3'd3, 32'h1, 8'h00, 1'b1);
        chk("lane3_first", 64'(lane_data(3)), 64'h1);
        offer(3'd3, 32'h2, 8'h08, 1'b1);
        chk("lane3_refill", 64'(lane_data(3)), 64'h2);
        chk("lane3_out_valid", 64'(bus.out_valid), 64'h2C);
        chk("lane3_count", 64'(disp_count), 64'h4);

        // Drain several lanes at once
        bus.out_ready = 8'hFF;
        @(posedge clk);
        #1;
        bus.out_ready = 8'h00;
        chk("drain_all_out_valid", 64'(bus.out_valid), 64'h00);
        chk("drain_all_busy", 64'(busy), 64'h0);
        chk("drain_all_sb_empty", 64'(sb.size()), 64'h0);

        // Fill all lanes, then flush with an offer pending
        for (int k = 0; k < 8; k++) offer(3'(k), 32'hA0 + 32'(k), 8'h00, 1'b1);
        chk("fill_out_valid", 64'(bus.out_valid), 64'hFF);
        chk("fill_count", 64'(disp_count), 64'd12);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.aluOP     = 3'd6;
        bus.in_data   = 32'h5555;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'h0);
        sb.delete();
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'h00);
        chk("flush_count", 64'(disp_count), 64'h0);
        chk("flush_busy", 64'(busy), 64'h0);

        // Asynchronous reset between edges while lanes are full
        offer(3'd1, 32'h11, 8'h00, 1'b1);
        offer(3'd6, 32'h66, 8'h00, 1'b1);
        chk("pre_reset_out_valid", 64'(bus.out_valid), 64'h42);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(bus.out_valid), 64'h00);
        chk("async_count", 64'(disp_count), 64'h0);
        chk("async_busy", 64'(busy), 64'h0);
        chk("async_lane6", 64'(lane_data(6)), 64'h0);
        sb.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_out_valid", 64'(bus.out_valid), 64'h00);
        offer(3'd4, 32'h44, 8'h00, 1'b1);
        chk("post_reset_out_valid2", 64'(bus.out_valid), 64'h10);
        chk("post_reset_count", 64'(disp_count), 64'h1);

        // Counter wrap after 65536 transfers
        flush = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("wrap_start_count", 64'(disp_count), 64'h0);
        bus.out_ready = 8'hFF;
        for (int i = 0; i < 65536; i++) begin
            bus.in_valid = 1'b1;
            bus.aluOP    = 3'(i);
            bus.in_data  = 32'(i);
            sb.push_back('{lane: 3'(i), data: 32'(i)});
            @(posedge clk);
            #1;
            if (i == 65534) chk("wrap_count_ffff", 64'(disp_count), 64'hFFFF);
        end
        bus.in_valid = 1'b0;
        chk("wrap_count_zero", 64'(disp_count), 64'h0);
        @(posedge clk);
        #1;
        bus.out_ready = 8'h00;
        chk("wrap_sb_empty", 64'(sb.size()), 64'h0);
        chk("wrap_idle", 64'(busy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/demux8_dispatch.md
DEMUX8_DISPATCH -- requirements
Module: demux8_dispatch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the per-lane data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous clear of all lanes, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream offers in_data and aluOP this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the offer this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: operand word to dispatch.
REQ-008 The block SHALL have port aluOP, input, 3 bits: destination lane index 0..7.
REQ-009 The block SHALL have port out_valid, output, 8 bits: bit k set means lane k holds a word.
REQ-010 The block SHALL have port out_ready, input, 8 bits: bit k set means the lane k consumer takes the word.
REQ-011 The block SHALL have port out_data, output, 8*WIDTH bits: lane k occupies bits [WIDTH*k+WIDTH-1 : WIDTH*k].
REQ-012 The block SHALL have port disp_count, output, 16 bits: total accepted words since reset or flush.
REQ-013 The block SHALL have port busy, output, 1 bit: OR of out_valid.

Function
REQ-014 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer on lane k SHALL occur on a cycle with out_valid[k]=1 and out_ready[k]=1.
REQ-015 Each lane SHALL be a one-entry register with two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-016 in_ready SHALL be combinational and equal (!flush) AND (out_valid[aluOP]=0 OR out_ready[aluOP]=1); in_ready SHALL NOT depend on in_valid.
REQ-017 On an input transfer, lane aluOP SHALL load in_data and be FULL on the next cycle.
REQ-018 Latency SHALL be one cycle: the word is visible on out_data lane aluOP with out_valid set in the cycle after acceptance.
REQ-019 Lane transitions:
- FULL->EMPTY on an output transfer with no input transfer to the same lane.
- An output transfer and an input transfer on the same lane in the same cycle SHALL leave the lane FULL with the new word.
- EMPTY->FULL only on an input transfer.
REQ-020 Lanes other than aluOP SHALL be unaffected by an input transfer; several lanes MAY drain in the same cycle.
REQ-021 out_data of an EMPTY lane SHALL hold its last value; consumers SHALL ignore it.
REQ-022 disp_count SHALL increment by 1 on each input transfer and wrap from 16'hFFFF to 16'h0000.
REQ-023 When flush=1, on the next edge all out_valid bits and disp_count SHALL clear; in_ready SHALL be 0 during flush, so no word is accepted and any coincident output handshakes are discarded.
REQ-024 A stall on lane k (FULL, out_ready[k]=0) SHALL block only offers whose aluOP equals k.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously force out_valid=8'h00, out_data=0, disp_count=0 and busy=0, independent of clk.
REQ-026 A reset asserted mid-operation SHALL discard all held words; the first edge after rst_n deasserts SHALL behave as from EMPTY.

Verification
REQ-027 The bench SHALL cover this scenario: reset, then offer in_data=32'hDEADBEEF with aluOP=5 and out_ready=8'h00 -> next cycle out_valid=8'h20, lane 5 = DEADBEEF, disp_count=1, busy=1.
REQ-028 The bench SHALL cover this scenario: with lane 5 FULL and out_ready[5]=0, offer aluOP=5 -> in_ready=0 and the lane is unchanged; offer aluOP=2 instead -> accepted, out_valid=8'h24.
REQ-029 The bench SHALL cover this scenario: with lane 3 FULL holding 32'h1, set out_ready[3]=1 and offer 32'h2 with aluOP=3 in the same cycle -> in_ready=1, next cycle lane 3 = 32'h2 and out_valid[3]=1.
REQ-030 The bench SHALL cover this scenario: fill all 8 lanes, then set flush=1 with in_valid=1 -> in_ready=0, next cycle out_valid=0, disp_count=0, busy=0.
REQ-031 The bench SHALL cover this scenario: complete 65536 transfers -> disp_count returns to 0.
REQ-032 The bench SHALL cover this scenario: pulse rst_n low between clock edges while lanes are FULL -> outputs clear before the next edge.
